// File: rtl/bch_dec_arbiter.sv
// bch_dec_arbiter: round-robin scheduler sharing one pipelined BCH(15,7)
// decoder between NREQ requesters.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_codeword/req_ready : requester side, one-hot combinational grant
//   dec_codeword -> decoder input; dec_corrected/dec_error_flag <- decoder output
//   rsp_valid/rsp_word/rsp_error     : registered response, one-hot owner
//   flush, clr_stats                 : synchronous control
//   busy, word_count, err_count      : status and saturating statistics
module bch_dec_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 6,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [15*NREQ-1:0]   req_codeword,
  output logic [NREQ-1:0]      req_ready,
  output logic [14:0]          dec_codeword,
  input  logic [14:0]          dec_corrected,
  input  logic                 dec_error_flag,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [14:0]          rsp_word,
  output logic                 rsp_error,
  input  logic                 flush,
  input  logic                 clr_stats,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned CW_W  = 15;
  localparam int unsigned IDX_W = 2;

  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [NREQ-1:0]               grant_c;
  logic                          grant_any_c;
  logic [IDX_W-1:0]              grant_idx_c;

  logic [LATENCY-1:0]            tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
  logic                          fire_c;

  logic [NREQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [CW_W-1:0]               rsp_word_q, rsp_word_d;
  logic                          rsp_error_q, rsp_error_d;
  logic                          busy_q, busy_d;
  logic [CNT_W-1:0]              word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]              err_cnt_q, err_cnt_d;

  // Round-robin pick: first valid at or above ptr, else wrap to the lowest valid.
  always_comb begin
    grant_c     = '0;
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    if (!flush) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!grant_any_c && req_valid[j] && (IDX_W'(j) >= ptr_q)) begin
          grant_any_c = 1'b1;
          grant_idx_c = IDX_W'(j);
        end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!grant_any_c && req_valid[j]) begin
          grant_any_c = 1'b1;
          grant_idx_c = IDX_W'(j);
        end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
        grant_c[j] = grant_any_c && (grant_idx_c == IDX_W'(j));
      end
    end
  end

  assign req_ready = grant_c;

  // Priority pointer moves just past the winner; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any_c) begin
      ptr_d = (grant_idx_c == IDX_W'(NREQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

  // Idle slots feed the all-zero codeword; its result is dropped by the tag valid.
  always_comb begin
    dec_codeword = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (grant_c[j]) begin
        dec_codeword = req_codeword[CW_W*j +: CW_W];
      end
    end
  end

  // Tag shift register aligned with decoder latency.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = grant_any_c;
    tag_idx_d[0] = grant_idx_c;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    if (flush) begin
      tag_vld_d = '0;
    end
  end

  assign fire_c = tag_vld_q[LATENCY-1] && !flush;
  assign busy_d = |tag_vld_d;

  // Response capture; word/error hold when nothing is delivered.
  always_comb begin
    rsp_valid_d = '0;
    rsp_word_d  = rsp_word_q;
    rsp_error_d = rsp_error_q;
    if (fire_c) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        rsp_valid_d[j] = (tag_idx_q[LATENCY-1] == IDX_W'(j));
      end
      rsp_word_d  = dec_corrected;
      rsp_error_d = dec_error_flag;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clr_stats) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (fire_c) begin
      if (word_cnt_q != {CNT_W{1'b1}}) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
      if (dec_error_flag && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_word_q  <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_word_q  <= rsp_word_d;
      rsp_error_q <= rsp_error_d;
      busy_q      <= busy_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_word   = rsp_word_q;
  assign rsp_error  = rsp_error_q;
  assign busy       = busy_q;
  assign word_count = word_cnt_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_bch_dec_arbiter.sv
// Bench for bch_dec_arbiter: behavioural BCH(15,7) decoder pipeline, an
// arbitration reference model and a response scoreboard. A second instance
// with 3-bit counters shares all inputs for the saturation check.
module tb_bch_dec_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned LATENCY = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [15*NREQ-1:0]  req_codeword;
  logic                flush, clr_stats;
  logic [14:0]         dec_corrected;
  logic                dec_error_flag;

  logic [NREQ-1:0]     req_ready, rsp_valid;
  logic [14:0]         dec_codeword, rsp_word;
  logic                rsp_error, busy;
  logic [15:0]         word_count, err_count;

  logic [NREQ-1:0]     req_ready3, rsp_valid3;
  logic [14:0]         dec_codeword3, rsp_word3;
  logic                rsp_error3, busy3;
  logic [2:0]          word_count3, err_count3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bch_dec_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_codeword(req_codeword),
    .req_ready(req_ready), .dec_codeword(dec_codeword),
    .dec_corrected(dec_corrected), .dec_error_flag(dec_error_flag),
    .rsp_valid(rsp_valid), .rsp_word(rsp_word), .rsp_error(rsp_error),
    .flush(flush), .clr_stats(clr_stats), .busy(busy),
    .word_count(word_count), .err_count(err_count));

  bch_dec_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_codeword(req_codeword),
    .req_ready(req_ready3), .dec_codeword(dec_codeword3),
    .dec_corrected(dec_corrected), .dec_error_flag(dec_error_flag),
    .rsp_valid(rsp_valid3), .rsp_word(rsp_word3), .rsp_error(rsp_error3),
    .flush(flush), .clr_stats(clr_stats), .busy(busy3),
    .word_count(word_count3), .err_count(err_count3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Nearest-codeword decoder: g(x) = x^8+x^7+x^6+x^4+1, corrects up to 2 errors.
  function automatic logic [15:0] bch_decode(input logic [14:0] w);
    logic [14:0] c;
    int          d;
    for (int m = 0; m < 128; m++) begin
      c = '0;
      for (int b = 0; b < 7; b++) begin
        if (((m >> b) & 1) == 1) c = c ^ (15'h1D1 << b);
      end
      d = $countones(c ^ w);
      if (d <= 2) return {(d != 0), c};
    end
    return {1'b1, w};
  endfunction

  logic [15:0] dpipe [LATENCY];
  always @(posedge clk) begin
    dpipe[0] <= bch_decode(dec_codeword);
    for (int i = 1; i < LATENCY; i++) dpipe[i] <= dpipe[i-1];
  end
  assign dec_corrected  = dpipe[LATENCY-1][14:0];
  assign dec_error_flag = dpipe[LATENCY-1][15];

  typedef struct {
    int          idx;
    logic [14:0] w;
    logic        e;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   gq[$];
  int   exp_ptr = 0;
  int   rsp_cnt = 0;

  // Monitor: response scoreboard, arbitration model, twin-instance agreement.
  always @(negedge clk) begin
    exp_t        e;
    int          g;
    int          j;
    logic [29:0] sh;
    logic [15:0] dd;
    if (!rst) begin
      sbq.delete();
      exp_ptr = 0;
    end else begin
      chk("twin_match",
          {req_ready3, dec_codeword3, rsp_valid3, rsp_word3, rsp_error3, busy3},
          {req_ready, dec_codeword, rsp_valid, rsp_word, rsp_error, busy});
      if (rsp_valid != '0) begin
        rsp_cnt++;
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_owner", rsp_valid, 1 << e.idx);
          chk("rsp_word", rsp_word, e.w);
          chk("rsp_error", rsp_error, e.e);
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        chk("rsp_missing", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (flush) sbq.delete();
      g = -1;
      if (!flush) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (exp_ptr + k) % NREQ;
          if (g < 0 && ((int'(req_valid) >> j) & 1) == 1) g = j;
        end
      end
      chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      if (g >= 0) begin
        sh = req_codeword >> (15 * g);
        chk("dec_codeword", dec_codeword, sh[14:0]);
        dd = bch_decode(sh[14:0]);
        e.idx = g;
        e.w   = dd[14:0];
        e.e   = dd[15];
        e.due = cyc + LATENCY + 1;
        sbq.push_back(e);
        gq.push_back(g);
        exp_ptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until granted (bounded); returns the grant cycle.
  task automatic send(input int i, input logic [14:0] w, output int at);
    bit got = 1'b0;
    at = -1;
    req_codeword[15*i +: 15] = w;
    req_valid = req_valid | NREQ'(1 << i);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (((int'(req_ready) >> i) & 1) == 1) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~NREQ'(1 << i);
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sbq.size() != 0; n++) tick();
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int at;
    int snap;
    rst = 1'b0;
    req_valid = '0;
    req_codeword = '0;
    flush = 1'b0;
    clr_stats = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_word", rsp_word, 0);
    chk("reset_busy", busy, 0);
    chk("reset_counts", {word_count, err_count, word_count3, err_count3}, 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // 1: single request latency, error corrected to zero
    send(0, 15'h0004, at);
    while (cyc < at + LATENCY) tick();
    @(negedge clk);
    chk("t1_not_early", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_word", rsp_word, 15'h0000);
    chk("t1_rsp_error", rsp_error, 1);
    chk("t1_word_count", word_count, 1);
    chk("t1_err_count", err_count, 1);
    tick();
    drain();

    // 2: round-robin fairness with both requesters always valid
    clear_stats();
    gq.delete();
    req_codeword = {15'h7FFE, 15'h7FFF};
    req_valid = 2'b11;
    repeat (20) tick();
    req_valid = '0;
    drain();
    chk("t2_grant_count", gq.size(), 20);
    for (int k = 1; k < gq.size(); k++) chk("t2_alternate", gq[k], 1 - gq[k-1]);
    chk("t2_word_count", word_count, 20);
    chk("t2_err_count", err_count, 10);

    // 3: flush two cycles after the last of four issues
    clear_stats();
    snap = rsp_cnt;
    for (int k = 0; k < 4; k++) begin
      req_codeword[14:0] = 15'h1230 + 15'(k);
      req_valid = 2'b01;
      tick();
    end
    req_valid = '0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("t3_busy_before", busy, 1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t3_busy_after", busy, 0);
    repeat (10) tick();
    chk("t3_no_responses", rsp_cnt - snap, 0);
    chk("t3_word_count", word_count, 0);
    send(1, 15'h0000, at);
    while (cyc < at + LATENCY + 1) tick();
    @(negedge clk);
    chk("t3_new_word", rsp_valid, 2'b10);
    tick();
    drain();

    // 4: saturation of 3-bit counters, then clear racing a response
    clear_stats();
    req_codeword[14:0] = 15'h0001;
    req_valid = 2'b01;
    repeat (10) tick();
    req_valid = '0;
    drain();
    chk("t4_sat_words3", word_count3, 3'h7);
    chk("t4_sat_errs3", err_count3, 3'h7);
    chk("t4_words16", word_count, 10);
    chk("t4_errs16", err_count, 10);
    send(0, 15'h0002, at);
    while (cyc < at + LATENCY) tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    @(negedge clk);
    chk("t4_coincident_rsp", rsp_valid, 2'b01);
    chk("t4_clr_counts", {word_count, err_count, word_count3, err_count3}, 0);
    tick();
    drain();

    // 5: reset with three words in flight
    clear_stats();
    send(0, 15'h7FFF, at);
    drain();
    req_codeword[14:0] = 15'h0003;
    req_valid = 2'b01;
    repeat (3) tick();
    req_valid = '0;
    tick();
    snap = rsp_cnt;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_rsp_word", rsp_word, 0);
    chk("t5_rst_rsp_error", rsp_error, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_counts", {word_count, err_count, word_count3, err_count3}, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (12) tick();
    chk("t5_no_stale", rsp_cnt - snap, 0);
    req_codeword = {15'h7FFE, 15'h7FFF};
    req_valid = 2'b11;
    @(negedge clk);
    chk("t5_tie_to_req0", req_ready, 2'b01);
    tick();
    req_valid = '0;
    drain();

    // 6: idle slots send zero and deliver nothing
    snap = rsp_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t6_dec_zero", dec_codeword, 0);
      chk("t6_rsp_idle", rsp_valid, 0);
      tick();
    end
    chk("t6_no_responses", rsp_cnt - snap, 0);
    chk("t6_word_count", word_count, 1);
    chk("t6_err_count", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bch_dec_arbiter.md
# bch_dec_arbiter

Round-robin arbiter and scheduler that shares one pipelined BCH(15,7) decoder instance between `NREQ` requesters. It accepts at most one codeword per cycle. It tags each accepted word with its requester index in a tag pipeline matched to the decoder latency, and routes each corrected word and error flag back to the owning requester. It also keeps saturating word and error statistics, and supports a synchronous flush of in-flight work.

## Interface

Parameters:

- `NREQ`, default 2: number of requesters, range 2..4.
- `LATENCY`, default 6: rising edges from `dec_codeword` being driven to the matching `dec_corrected`/`dec_error_flag` being valid at the decoder outputs.
- `CNT_W`, default 16: width of each statistics counter.

Ports:

- `clk`, in, 1: the single clock; all state is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NREQ`: requester i has a codeword to decode.
- `req_codeword`, in, 15*`NREQ`: requester i's word occupies bits [15i+14:15i].
- `req_ready`, out, `NREQ`: one-hot grant; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `dec_codeword`, out, 15: word driven to the decoder `codeword` input.
- `dec_corrected`, in, 15: decoder corrected word.
- `dec_error_flag`, in, 1: decoder error-found flag, aligned with `dec_corrected`.
- `rsp_valid`, out, `NREQ`: one-hot; a response for requester i is present this cycle.
- `rsp_word`, out, 15: corrected word.
- `rsp_error`, out, 1: the decoder reported an error for this word.
- `flush`, in, 1: synchronous discard of all in-flight words.
- `clr_stats`, in, 1: synchronous clear of both counters.
- `busy`, out, 1: at least one tag is in flight.
- `word_count`, out, `CNT_W`: responses delivered.
- `err_count`, out, `CNT_W`: responses delivered with `rsp_error` = 1.

## Operation

**Arbitration**
- `req_ready` is combinational from `req_valid`, `flush` and the priority pointer `ptr`.
- The grant goes to the first valid requester at or after `ptr`, searching modulo `NREQ`.
- After a grant to requester i, `ptr` becomes (i+1) mod `NREQ`. With no grant, `ptr` holds.
- `ptr` resets to 0.
- While `flush` = 1, `req_ready` = 0 and no grant occurs.

**Decoder drive**
- `dec_codeword` equals the granted requester's word in the grant cycle, otherwise 15'h0000.
- An idle slot sends the all-zero codeword, which is a valid codeword. Its result is never delivered.

**Tag pipeline**
- The tag pipeline has `LATENCY` stages. Each stage holds {valid, index[1:0]}.
- Stage 0 loads {grant_any, granted index}.
- Each stage shifts forward by one every cycle. There is no backpressure; responders must always accept.
- `busy` = OR of all stage valid bits.

**Response**
- Response outputs are registered.
- When the final stage is valid, the next edge loads:
  - `rsp_valid` = one-hot(index),
  - `rsp_word` = `dec_corrected`,
  - `rsp_error` = `dec_error_flag`.
- Otherwise `rsp_valid` = 0, and `rsp_word`/`rsp_error` hold their previous values.

**Flush**
- `flush` = 1 clears every stage valid bit at the edge. Those words are never delivered.
- `rsp_valid` = 0 in the following cycle.
- Issue may resume in the cycle after `flush` drops.

**Statistics**
- On a delivered response, `word_count` increments by 1. `err_count` increments by 1 as well when `rsp_error` = 1.
- Both counters saturate at all-ones and never wrap.
- `clr_stats` zeroes both counters and takes priority over a simultaneous increment.

**Reset**
- While `rst` = 0, asynchronously:
  - all tag valid bits = 0, `ptr` = 0;
  - `rsp_valid` = 0, `rsp_word` = 0, `rsp_error` = 0;
  - `word_count` = 0, `err_count` = 0;
  - `busy` = 0.
- Reset mid-operation discards every in-flight word.
- `req_ready` and `dec_codeword` are combinational and follow their rules regardless of reset. Requesters must not issue during reset.

## Timing

- A transfer in cycle t yields `rsp_valid` in cycle t+`LATENCY`+1. Throughput is one word per cycle.
- With k requesters continuously valid, each is granted exactly once every k cycles.
- A request held valid with no grant must keep its word stable.
- `flush` asserted in cycle t:
  - suppresses the grant in cycle t;
  - causes no responses in cycles t+1 through t+`LATENCY`+1 for words issued before t+1;
  - `busy` = 0 from cycle t+1.
- `clr_stats` and an increment in the same cycle: the counter reads 0 the next cycle.

## Test plan

1. **Single request latency.** Requester 0 sends 15'h0004 in cycle 10 (default params). Required: `rsp_valid` = 2'b01 in cycle 17, `rsp_word` = 15'h0000, `rsp_error` = 1, `err_count` = 1, `word_count` = 1.
2. **Round-robin fairness.** Both requesters hold valid for 20 cycles: requester 0 with 15'h7FFF, requester 1 with 15'h7FFE. Required:
   - grants alternate 0, 1, 0, 1…;
   - responses alternate, with requester 0 getting 15'h7FFF/`rsp_error` = 0 and requester 1 getting 15'h7FFF/`rsp_error` = 1;
   - final counts are `word_count` = 20, `err_count` = 10.
3. **Flush mid-flight.** Issue 4 words, then assert `flush` for 1 cycle two cycles after the last issue. Required: no `rsp_valid` for any of the 4, `busy` = 0 the cycle after `flush`, and a new word issued afterwards returns after 7 cycles.
4. **Saturation and clear.** With `CNT_W` = 3, deliver 10 error words. Required: both counters saturate at 3'h7. Then assert `clr_stats` coincident with a response. Required: both counters read 0 the next cycle.
5. **Reset mid-operation.** Pulse `rst` low while 3 words are in flight. Required: all outputs at their reset values while low, no stale responses afterwards, and `ptr` at 0 so requester 0 wins a tie against requester 1.
6. **Idle slot.** `req_valid` = 0 for 10 cycles. Required: `dec_codeword` = 0, `rsp_valid` stays 0, and the counters are unchanged.
